// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the two-requester memory port arbiter:
// state encoding, default bus widths and the latency counter width.
package mem_port_arbiter_pkg;

    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned ADDR_W_DEF = 16;
    localparam int unsigned CNT_W      = 4;

    // 2'b11 is unused and recovers to IDLE.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } state_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester handshake and memory port bundle of the arbiter.
// slave = arbiter side, master = requesters plus memory side.
interface mem_port_arbiter_if
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
);

    logic              req0;
    logic              we0;
    logic [ADDR_W-1:0] addr0;
    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    logic              gnt0;
    logic              gnt1;
    logic              done0;
    logic              done1;
    logic [DATA_W-1:0] rdata;
    logic              md_sel;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  req0, we0, addr0, req1, we1, addr1, mem_rdata,
        output gnt0, gnt1, done0, done1, rdata, md_sel, mem_en, mem_we, mem_addr
    );

    modport master (
        output req0, we0, addr0, req1, we1, addr1, mem_rdata,
        input  gnt0, gnt1, done0, done1, rdata, md_sel, mem_en, mem_we, mem_addr
    );

endinterface

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Two-way round-robin pick: a lone request wins outright, a tie goes to
// the requester that was not served last.
module rr_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic valid,
    output logic winner
);

    always_comb begin
        valid  = req0 | req1;
        winner = (req0 & req1) ? ~last : req1;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serializes two requesters onto one memory port: IDLE -> ACCESS (MEM_LAT
// cycles) -> RESP, with registered grant, memory control and done pulse.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned MEM_LAT = 2
) (
    input logic               CLK,
    input logic               Reset,
    mem_port_arbiter_if.slave bus
);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              last;
    logic              pick_valid;
    logic              pick_win;
    logic              gnt0, gnt1, done0, done1;
    logic              md_sel, mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] rdata;

    rr_pick2 u_pick (
        .req0   (bus.req0),
        .req1   (bus.req1),
        .last   (last),
        .valid  (pick_valid),
        .winner (pick_win)
    );

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            cnt      <= '0;
            last     <= 1'b1;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            done0    <= 1'b0;
            done1    <= 1'b0;
            rdata    <= '0;
            md_sel   <= 1'b0;
            mem_en   <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
        end else begin
            done0 <= 1'b0;
            done1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        mem_addr <= pick_win ? bus.addr1 : bus.addr0;
                        mem_we   <= pick_win ? bus.we1 : bus.we0;
                        md_sel   <= pick_win;
                        gnt0     <= ~pick_win;
                        gnt1     <= pick_win;
                        mem_en   <= 1'b1;
                        cnt      <= CNT_W'(MEM_LAT - 1);
                        last     <= pick_win;
                        state    <= ACCESS;
                    end else begin
                        mem_en <= 1'b0;
                        mem_we <= 1'b0;
                        gnt0   <= 1'b0;
                        gnt1   <= 1'b0;
                    end
                end
                ACCESS: begin
                    if (cnt == '0) begin
                        // mem_we still holds the latched direction of this access
                        if (!mem_we)
                            rdata <= bus.mem_rdata;
                        gnt0   <= 1'b0;
                        gnt1   <= 1'b0;
                        mem_en <= 1'b0;
                        mem_we <= 1'b0;
                        done0  <= ~last;
                        done1  <= last;
                        state  <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: state <= IDLE;
                default: begin
                    gnt0   <= 1'b0;
                    gnt1   <= 1'b0;
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.gnt0     = gnt0;
    assign bus.gnt1     = gnt1;
    assign bus.done0    = done0;
    assign bus.done1    = done1;
    assign bus.rdata    = rdata;
    assign bus.md_sel   = md_sel;
    assign bus.mem_en   = mem_en;
    assign bus.mem_we   = mem_we;
    assign bus.mem_addr = mem_addr;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with MEM_LAT=2: a per-cycle vector
// table plus hand-written fairness and async-reset sequences.
module tb_mem_port_arbiter;

    logic CLK = 1'b0;
    logic Reset = 1'b1;
    int   nchecks = 0;
    int   nfails = 0;

    always #5 CLK = ~CLK;

    mem_port_arbiter_if #(.DATA_W(16), .ADDR_W(16)) bus ();

    mem_port_arbiter #(.DATA_W(16), .ADDR_W(16), .MEM_LAT(2)) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    typedef struct {
        logic        r0, w0;
        logic [15:0] a0;
        logic        r1, w1;
        logic [15:0] a1, mrd;
        logic        g0, g1, d0, d1, sel, en, we;
        logic [15:0] ea, erd;
    } vec_t;

    vec_t tbl [15];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        nchecks++;
        if (act !== exp) begin
            nfails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r0, input logic w0, input logic [15:0] a0,
                         input logic r1, input logic w1, input logic [15:0] a1,
                         input logic [15:0] mrd);
        bus.req0 = r0; bus.we0 = w0; bus.addr0 = a0;
        bus.req1 = r1; bus.we1 = w1; bus.addr1 = a1;
        bus.mem_rdata = mrd;
    endtask

    task automatic do_reset();
        drive(0, 0, 16'h0, 0, 0, 16'h0, 16'h0);
        Reset = 1'b1;
        repeat (3) @(posedge CLK);
        #1 Reset = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{1,0,16'h0040, 0,0,16'h0000, 16'h0000,  0,0,0,0,0,0,0, 16'h0000, 16'h0000};
        tbl[1]  = '{1,0,16'h0040, 0,0,16'h0000, 16'h0000,  1,0,0,0,0,1,0, 16'h0040, 16'h0000};
        tbl[2]  = '{1,0,16'h0040, 0,0,16'h0000, 16'hBEEF,  1,0,0,0,0,1,0, 16'h0040, 16'h0000};
        tbl[3]  = '{1,0,16'h0040, 0,0,16'h0000, 16'h0000,  0,0,1,0,0,0,0, 16'h0040, 16'hBEEF};
        tbl[4]  = '{0,0,16'h0000, 0,0,16'h0000, 16'h0000,  0,0,0,0,0,0,0, 16'h0040, 16'hBEEF};
        tbl[5]  = '{0,0,16'h0000, 1,1,16'h0010, 16'h0000,  0,0,0,0,0,0,0, 16'h0040, 16'hBEEF};
        tbl[6]  = '{0,0,16'h0000, 1,1,16'h0010, 16'hDEAD,  0,1,0,0,1,1,1, 16'h0010, 16'hBEEF};
        tbl[7]  = '{0,0,16'h0000, 1,1,16'h0010, 16'hDEAD,  0,1,0,0,1,1,1, 16'h0010, 16'hBEEF};
        tbl[8]  = '{0,0,16'h0000, 1,1,16'h0010, 16'h0000,  0,0,0,1,1,0,0, 16'h0010, 16'hBEEF};
        tbl[9]  = '{0,0,16'h0000, 0,0,16'h0000, 16'h0000,  0,0,0,0,1,0,0, 16'h0010, 16'hBEEF};
        tbl[10] = '{1,0,16'h0033, 0,0,16'h0000, 16'h0000,  0,0,0,0,1,0,0, 16'h0010, 16'hBEEF};
        tbl[11] = '{0,1,16'hFFFF, 0,0,16'h0000, 16'h0000,  1,0,0,0,0,1,0, 16'h0033, 16'hBEEF};
        tbl[12] = '{0,1,16'hFFFF, 0,0,16'h0000, 16'h5555,  1,0,0,0,0,1,0, 16'h0033, 16'hBEEF};
        tbl[13] = '{0,0,16'h0000, 0,0,16'h0000, 16'h0000,  0,0,1,0,0,0,0, 16'h0033, 16'h5555};
        tbl[14] = '{0,0,16'h0000, 0,0,16'h0000, 16'h0000,  0,0,0,0,0,0,0, 16'h0033, 16'h5555};

        // Reset held 3 cycles, then 5 idle cycles with every output low
        do_reset();
        for (int unsigned c = 0; c < 5; c++) begin
            chk("rst_gnt",   {14'h0, bus.gnt1, bus.gnt0}, 16'h0);
            chk("rst_done",  {14'h0, bus.done1, bus.done0}, 16'h0);
            chk("rst_ctl",   {13'h0, bus.md_sel, bus.mem_en, bus.mem_we}, 16'h0);
            chk("rst_addr",  bus.mem_addr, 16'h0);
            chk("rst_rdata", bus.rdata, 16'h0);
            @(posedge CLK); #1;
        end

        // Read by 0, write by 1, read by 0 dropping req mid-access
        for (int unsigned i = 0; i < 15; i++) begin
            drive(tbl[i].r0, tbl[i].w0, tbl[i].a0, tbl[i].r1, tbl[i].w1, tbl[i].a1, tbl[i].mrd);
            chk($sformatf("v%0d_gnt", i),  {14'h0, bus.gnt1, bus.gnt0},   {14'h0, tbl[i].g1, tbl[i].g0});
            chk($sformatf("v%0d_done", i), {14'h0, bus.done1, bus.done0}, {14'h0, tbl[i].d1, tbl[i].d0});
            chk($sformatf("v%0d_ctl", i),  {13'h0, bus.md_sel, bus.mem_en, bus.mem_we},
                                           {13'h0, tbl[i].sel, tbl[i].en, tbl[i].we});
            chk($sformatf("v%0d_addr", i), bus.mem_addr, tbl[i].ea);
            chk($sformatf("v%0d_rdata", i), bus.rdata, tbl[i].erd);
            @(posedge CLK); #1;
        end

        // Both requesters held high: 0,1,0,1 with done at cycles 3,7,11,15
        do_reset();
        for (int unsigned c = 0; c < 17; c++) begin
            int unsigned ph, w;
            logic [15:0] eaddr, erd;
            ph = c % 4;
            w  = (c / 4) % 2;
            eaddr = (c == 0) ? 16'h0 : ((((c - 1) / 4) % 2) != 0 ? 16'h0200 : 16'h0100);
            erd   = (c < 3) ? 16'h0 : 16'(16'hA000 + 4 * ((c - 3) / 4) + 2);
            drive(1, 0, 16'h0100, 1, 0, 16'h0200, 16'(16'hA000 + c));
            chk($sformatf("rr%0d_gnt0", c),  {15'h0, bus.gnt0},  {15'h0, (ph == 1 || ph == 2) && w == 0});
            chk($sformatf("rr%0d_gnt1", c),  {15'h0, bus.gnt1},  {15'h0, (ph == 1 || ph == 2) && w == 1});
            chk($sformatf("rr%0d_done0", c), {15'h0, bus.done0}, {15'h0, ph == 3 && w == 0});
            chk($sformatf("rr%0d_done1", c), {15'h0, bus.done1}, {15'h0, ph == 3 && w == 1});
            chk($sformatf("rr%0d_excl", c),  {15'h0, bus.gnt0 & bus.gnt1}, 16'h0);
            chk($sformatf("rr%0d_addr", c),  bus.mem_addr, eaddr);
            chk($sformatf("rr%0d_rdata", c), bus.rdata, erd);
            @(posedge CLK); #1;
        end

        // Async reset during cycle 1 of a write by requester 0, then normal service
        do_reset();
        drive(1, 1, 16'h0080, 0, 0, 16'h0, 16'h0);
        chk("ar_c0_gnt0", {15'h0, bus.gnt0}, 16'h0);
        @(posedge CLK); #1;
        chk("ar_c1_gnt0", {15'h0, bus.gnt0}, 16'h1);
        chk("ar_c1_we",   {15'h0, bus.mem_we}, 16'h1);
        #2 Reset = 1'b1;
        #1;
        chk("ar_async_gnt0", {15'h0, bus.gnt0}, 16'h0);
        chk("ar_async_en",   {15'h0, bus.mem_en}, 16'h0);
        chk("ar_async_we",   {15'h0, bus.mem_we}, 16'h0);
        chk("ar_async_addr", bus.mem_addr, 16'h0);
        for (int unsigned c = 0; c < 2; c++) begin
            @(posedge CLK); #1;
            chk("ar_held_done0", {15'h0, bus.done0}, 16'h0);
        end
        Reset = 1'b0;
        for (int unsigned c = 0; c < 5; c++) begin
            if (c == 4)
                drive(0, 0, 16'h0, 0, 0, 16'h0, 16'h0);
            chk($sformatf("ar%0d_gnt0", c),  {15'h0, bus.gnt0},   {15'h0, c == 1 || c == 2});
            chk($sformatf("ar%0d_we", c),    {15'h0, bus.mem_we}, {15'h0, c == 1 || c == 2});
            chk($sformatf("ar%0d_done0", c), {15'h0, bus.done0},  {15'h0, c == 3});
            @(posedge CLK); #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nchecks, nfails);
        $finish;
    end

endmodule
